// File: rtl/xup_tri_bus_arbiter_if.sv
// xup_tri_bus_arbiter_if: request/grant bundle between the requesters and the
// tri-state enable arbiter; master is the arbiter side, slave the requester side.
interface xup_tri_bus_arbiter_if #(
   parameter int NREQ = 4,
   parameter int IDXW = 2
);
   logic [NREQ-1:0] req;
   logic [NREQ-1:0] grant;
   logic            bus_en;
   logic [IDXW-1:0] owner;
   logic            busy;
   logic            revoke;
   modport master (input req, output grant, bus_en, owner, busy, revoke);
   modport slave (output req, input grant, bus_en, owner, busy, revoke);
endinterface

// File: rtl/xup_tri_bus_arbiter.sv
// xup_tri_bus_arbiter: round-robin one-hot tri-state enable generator with DEAD idle cycles
// between owners; XUP_TRI_BUS_ARBITER_TIMEOUT_EN adds a MAX_HOLD revoke when others wait.
module xup_tri_bus_arbiter #(
   parameter int NREQ     = 4,
   parameter int IDXW     = 2,
   parameter int DEAD     = 2,
   parameter int MAX_HOLD = 8
) (
   input logic                   clk,
   input logic                   rst_n,
   xup_tri_bus_arbiter_if.master bus
);
   typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;
   state_t          state_q;
   logic [IDXW-1:0] ptr_q, owner_q, sel_d, ptr_d, hi_idx, lo_idx;
   logic [NREQ-1:0] grant_q;
   logic [3:0]      dead_q;
   logic            busy_q, found_d, hi_hit;
`ifdef XUP_TRI_BUS_ARBITER_TIMEOUT_EN
   logic [7:0]      hold_q;
   logic            revoke_q;
`endif

   if (IDXW != $clog2(NREQ) || DEAD < 1 || DEAD > 15 || MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_param_check
      $error("xup_tri_bus_arbiter: illegal parameter combination");
   end

   // Lowest set bit at or above ptr wins; otherwise the lowest set bit overall (wrap).
   always_comb begin
      hi_idx  = '0;
      lo_idx  = '0;
      hi_hit  = 1'b0;
      found_d = 1'b0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (bus.req[i]) begin
            lo_idx  = IDXW'(i);
            found_d = 1'b1;
         end
         if (bus.req[i] && i >= int'(ptr_q)) begin
            hi_idx = IDXW'(i);
            hi_hit = 1'b1;
         end
      end
      sel_d = hi_hit ? hi_idx : lo_idx;
      ptr_d = (int'(sel_d) == NREQ - 1) ? '0 : sel_d + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         owner_q <= '0;
         grant_q <= '0;
         dead_q  <= '0;
         busy_q  <= 1'b0;
`ifdef XUP_TRI_BUS_ARBITER_TIMEOUT_EN
         hold_q   <= '0;
         revoke_q <= 1'b0;
`endif
      end else begin
`ifdef XUP_TRI_BUS_ARBITER_TIMEOUT_EN
         revoke_q <= 1'b0;
`endif
         case (state_q)
            IDLE, TURN: begin
               if (state_q == IDLE || dead_q == '0) begin
                  if (found_d) begin
                     grant_q <= NREQ'(1) << sel_d;
                     owner_q <= sel_d;
                     ptr_q   <= ptr_d;
                     busy_q  <= 1'b1;
                     state_q <= GRANT;
`ifdef XUP_TRI_BUS_ARBITER_TIMEOUT_EN
                     hold_q  <= '0;
`endif
                  end else begin
                     busy_q  <= 1'b0;
                     state_q <= IDLE;
                  end
               end else begin
                  dead_q <= dead_q - 4'd1;
               end
            end
            GRANT: begin
               if ((bus.req & grant_q) == '0) begin
                  grant_q <= '0;
                  dead_q  <= 4'(DEAD - 1);
                  state_q <= TURN;
               end
`ifdef XUP_TRI_BUS_ARBITER_TIMEOUT_EN
               else if (hold_q == 8'(MAX_HOLD - 1) && (bus.req & ~grant_q) != '0) begin
                  grant_q  <= '0;
                  dead_q   <= 4'(DEAD - 1);
                  state_q  <= TURN;
                  revoke_q <= 1'b1;
               end else if (hold_q != 8'(MAX_HOLD - 1)) begin
                  hold_q <= hold_q + 8'd1;
               end
`endif
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.grant  = grant_q;
   assign bus.bus_en = |grant_q;
   assign bus.owner  = owner_q;
   assign bus.busy   = busy_q;
`ifdef XUP_TRI_BUS_ARBITER_TIMEOUT_EN
   assign bus.revoke = revoke_q;
`else
   assign bus.revoke = 1'b0;
`endif
endmodule

// File: tb/tb_xup_tri_bus_arbiter.sv
// tb_xup_tri_bus_arbiter: scenario tasks plus random traffic checked against an
// integer-level model of the arbitration rules (NREQ=4, DEAD=2, MAX_HOLD=8; extra NREQ=3 instance).
module tb_xup_tri_bus_arbiter;
   localparam int NREQ = 4, DEAD = 2, MAX_HOLD = 8;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0, errors = 0;
   int   m_own, m_last, m_ptr, m_gap, m_hold;
   logic m_rev;
   logic [8:0] obs;

   always #5 clk = ~clk;

   xup_tri_bus_arbiter_if #(.NREQ(4), .IDXW(2)) bus ();
   xup_tri_bus_arbiter_if #(.NREQ(3), .IDXW(2)) bus3 ();

   xup_tri_bus_arbiter #(.NREQ(4), .IDXW(2), .DEAD(DEAD), .MAX_HOLD(MAX_HOLD)) u_dut (
      .clk(clk), .rst_n(rst_n), .bus(bus));
   xup_tri_bus_arbiter #(.NREQ(3), .IDXW(2), .DEAD(DEAD), .MAX_HOLD(MAX_HOLD)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .bus(bus3));

   assign obs = {bus.grant, bus.bus_en, bus.owner, bus.busy, bus.revoke};

   task automatic model_reset();
      m_own = -1; m_last = 0; m_ptr = 0; m_gap = 0; m_hold = 0; m_rev = 1'b0;
   endtask

   task automatic arbitrate(input logic [3:0] r);
      for (int k = 0; k < NREQ; k++) begin
         int i;
         i = (m_ptr + k) % NREQ;
         if (m_own < 0 && r[i]) begin
            m_own = i; m_last = i; m_ptr = (i + 1) % NREQ; m_hold = 0;
         end
      end
   endtask

   // One rising edge of the reference: owner keeps the bus while its req is up,
   // then DEAD empty cycles, then a round-robin pick from the pointer.
   task automatic model_step(input logic [3:0] r);
      m_rev = 1'b0;
      if (m_own >= 0) begin
         if (!r[m_own]) begin
            m_own = -1; m_gap = DEAD;
         end
`ifdef XUP_TRI_BUS_ARBITER_TIMEOUT_EN
         else if (m_hold == MAX_HOLD - 1 && (r & ~(4'b0001 << m_own)) != 4'b0) begin
            m_own = -1; m_gap = DEAD; m_rev = 1'b1;
         end else if (m_hold < MAX_HOLD - 1) m_hold++;
`endif
      end else if (m_gap > 1) m_gap--;
      else begin
         m_gap = 0;
         arbitrate(r);
      end
   endtask

   function automatic logic [8:0] exp_vec();
      logic [3:0] g;
      g = (m_own >= 0) ? 4'(1 << m_own) : 4'b0;
      return {g, m_own >= 0, 2'(m_last), (m_own >= 0 || m_gap > 0), m_rev};
   endfunction

   task automatic tick(input logic [3:0] r);
      bus.req = r;
      @(posedge clk);
      model_step(r);
      @(negedge clk);
   endtask

   task automatic do_reset();
      bus.req = '0; bus3.req = '0; rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      bus.req = '0; bus3.req = '0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (obs !== 9'b0) begin errors++; $display("FAIL reset4: got %b want 0", obs); end
      checks++;
      if ({bus3.grant, bus3.bus_en, bus3.owner, bus3.busy, bus3.revoke} !== 8'b0) begin
         errors++; $display("FAIL reset3: got %b want 0", {bus3.grant, bus3.owner, bus3.busy});
      end
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_single();
      do_reset();
      for (int i = 0; i < 4; i++) tick(4'b0000);
      for (int i = 0; i < 10; i++) begin
         tick(i < 5 ? 4'b0010 : 4'b0000);
         checks++;
         if (obs !== exp_vec()) begin errors++; $display("FAIL single_model[%0d]: got %b want %b", i, obs, exp_vec()); end
         checks++;
         if (bus.grant !== (i < 5 ? 4'b0010 : 4'b0000) || bus.busy !== (i < 7) || (i < 5 && bus.owner !== 2'd1)) begin
            errors++; $display("FAIL single_timing[%0d]: grant %b busy %b owner %0d", i, bus.grant, bus.busy, bus.owner);
         end
      end
   endtask

   task automatic test_round_robin();
      logic [3:0] want [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      logic [3:0] g, r;
      int age = 0, rec = 0, zrun = 0;
      do_reset();
      for (int n = 0; n < 60 && rec < 5; n++) begin
         g = bus.grant;
         age = (g != 0) ? age + 1 : 0;
         if (g != 0 && age == 1) begin
            checks++;
            if (g !== want[rec]) begin errors++; $display("FAIL rr_order[%0d]: got %b want %b", rec, g, want[rec]); end
            if (rec > 0) begin
               checks++;
               if (zrun != DEAD) begin errors++; $display("FAIL rr_gap[%0d]: got %0d want %0d", rec, zrun, DEAD); end
            end
            rec++;
         end
         zrun = (g == 0) ? zrun + 1 : 0;
         r = (age >= 2) ? (4'hF & ~g) : 4'hF;
         tick(r);
         checks++;
         if (obs !== exp_vec()) begin errors++; $display("FAIL rr_model[%0d]: got %b want %b", n, obs, exp_vec()); end
      end
      checks++;
      if (rec != 5) begin errors++; $display("FAIL rr_count: got %0d want 5", rec); end
   endtask

   task automatic test_wrap();
      int n = 0;
      do_reset();
      bus3.req = 3'b100;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus3.grant !== 3'b100 || bus3.owner !== 2'd2) begin
         errors++; $display("FAIL wrap_first: grant %b owner %0d want 100/2", bus3.grant, bus3.owner);
      end
      bus3.req = 3'b011;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         @(negedge clk);
         n++;
         checks++;
         if (bus3.owner > 2'd2) begin errors++; $display("FAIL wrap_owner: got %0d want <3", bus3.owner); end
         if (bus3.grant != 0) break;
      end
      checks++;
      if (n != DEAD + 1 || bus3.grant !== 3'b001 || bus3.owner !== 2'd0) begin
         errors++; $display("FAIL wrap_next: after %0d grant %b owner %0d want 3/001/0", n, bus3.grant, bus3.owner);
      end
      bus3.req = '0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      tick(4'b0100);
      checks++;
      if (bus.grant !== 4'b0100 || obs !== exp_vec()) begin errors++; $display("FAIL rmid_pre: got %b want grant 0100", obs); end
      rst_n = 1'b0;
      #1;
      checks++;
      if (obs !== 9'b0) begin errors++; $display("FAIL rmid_async: got %b want 0", obs); end
      #1;
      rst_n = 1'b1;
      model_reset();
      tick(4'b1100);
      checks++;
      if (bus.grant !== 4'b0100 || bus.owner !== 2'd2 || obs !== exp_vec()) begin
         errors++; $display("FAIL rmid_post: got %b want grant 0100 owner 2", obs);
      end
   endtask

   task automatic test_timeout();
      int gcnt = 0, zcnt = 0, revs = 0;
      do_reset();
      for (int i = 0; i < 2; i++) begin
         tick(4'b0001);
         if (bus.grant == 4'b0001) gcnt++;
      end
      for (int i = 0; i < 40; i++) begin
         tick(4'b1001);
         checks++;
         if (obs !== exp_vec()) begin errors++; $display("FAIL to_model[%0d]: got %b want %b", i, obs, exp_vec()); end
         if (bus.revoke) revs++;
         if (bus.grant == 4'b0001) gcnt++;
         else if (bus.grant == 4'b0000) zcnt++;
         else break;
      end
`ifdef XUP_TRI_BUS_ARBITER_TIMEOUT_EN
      checks++;
      if (gcnt != MAX_HOLD || revs != 1 || zcnt != DEAD || bus.grant !== 4'b1000) begin
         errors++; $display("FAIL timeout: hold %0d rev %0d zero %0d grant %b want 8/1/2/1000", gcnt, revs, zcnt, bus.grant);
      end
`else
      checks++;
      if (gcnt != 42 || revs != 0 || bus.grant !== 4'b0001) begin
         errors++; $display("FAIL no_timeout: hold %0d rev %0d grant %b want 42/0/0001", gcnt, revs, bus.grant);
      end
`endif
   endtask

   task automatic test_random();
      logic [3:0] r = '0, g, prev = '0;
      int zrun = 0;
      bit seen = 0;
      do_reset();
      for (int n = 0; n < 10000; n++) begin
         r = r ^ 4'($urandom & $urandom);
         tick(r);
         g = bus.grant;
         checks++;
         if (obs !== exp_vec()) begin errors++; $display("FAIL rnd_model[%0d]: got %b want %b", n, obs, exp_vec()); end
         checks++;
         if ($countones(g) > 1) begin errors++; $display("FAIL rnd_onehot[%0d]: grant %b", n, g); end
         if (g != 0) begin
            if (prev == 0 && seen) begin
               checks++;
               if (zrun < DEAD) begin errors++; $display("FAIL rnd_gap[%0d]: got %0d want >=%0d", n, zrun, DEAD); end
            end else if (prev != 0) begin
               checks++;
               if (g != prev) begin errors++; $display("FAIL rnd_switch[%0d]: %b -> %b", n, prev, g); end
            end
            seen = 1;
            zrun = 0;
         end else zrun++;
         prev = g;
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_single();
      test_round_robin();
      test_wrap();
      test_reset_mid();
      test_timeout();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end
endmodule
